// File: rtl/mips_state_sequencer.sv
// ============================================================================
// Module   : mips_state_sequencer
// Brief    : Multicycle state sequencer for the MIPS core: fetch/decode/
//            execute/memory/write-back stepping, bus stalls, halt detection.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_state_sequencer #(
  parameter int          CNT_W     = 32,
  parameter logic [31:0] HALT_ADDR = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       func_code,
  input  logic             waitrequest,
  input  logic [31:0]      pc_next,
  output logic [2:0]       state,
  output logic             active,
  output logic             illegal,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_FETCH         = 3'd0,
    S_DECODE        = 3'd1,
    S_EXECUTE       = 3'd2,
    S_MEMORY_ACCESS = 3'd3,
    S_WRITE_BACK    = 3'd4,
    S_HALTED        = 3'd5
  } state_t;

  localparam logic [5:0]       c_ADDU  = 6'b100001;
  localparam logic [5:0]       c_JR    = 6'b001000;
  localparam logic [5:0]       c_ADDIU = 6'b001001;
  localparam logic [5:0]       c_LW    = 6'b100011;
  localparam logic [5:0]       c_SW    = 6'b101011;
  localparam logic [CNT_W-1:0] c_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_next_state;
  logic             r_illegal;
  logic [CNT_W-1:0] r_cycle_count;
  logic [CNT_W-1:0] r_instr_count;

  logic w_is_r;
  logic w_addu;
  logic w_jr;
  logic w_addiu;
  logic w_lw;
  logic w_sw;
  logic w_retire;
  logic w_set_illegal;

  // R-type instructions are selected by func_code, everything else by opcode.
  assign w_is_r  = (opcode == 6'd0);
  assign w_addu  = w_is_r  && (func_code == c_ADDU);
  assign w_jr    = w_is_r  && (func_code == c_JR);
  assign w_addiu = !w_is_r && (opcode == c_ADDIU);
  assign w_lw    = !w_is_r && (opcode == c_LW);
  assign w_sw    = !w_is_r && (opcode == c_SW);

  always_comb begin
    w_next_state  = r_state;
    w_retire      = 1'b0;
    w_set_illegal = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (!waitrequest) w_next_state = S_DECODE;
      end
      S_DECODE: begin
        w_next_state = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (w_addu || w_addiu || w_lw || w_sw) begin
          w_next_state = S_MEMORY_ACCESS;
        end else if (w_jr) begin
          w_retire = 1'b1;
        end else begin
          w_set_illegal = 1'b1;
          w_next_state  = S_HALTED;
        end
      end
      S_MEMORY_ACCESS: begin
        // ALU ops pass through without touching the bus, so no stall applies.
        if (w_lw) begin
          if (!waitrequest) w_next_state = S_WRITE_BACK;
        end else if (w_sw) begin
          if (!waitrequest) w_retire = 1'b1;
        end else if (w_addu || w_addiu) begin
          w_retire = 1'b1;
        end else begin
          w_set_illegal = 1'b1;
          w_next_state  = S_HALTED;
        end
      end
      S_WRITE_BACK: begin
        w_retire = 1'b1;
      end
      S_HALTED: begin
        w_next_state = S_HALTED;
      end
      default: begin
        w_set_illegal = 1'b1;
        w_next_state  = S_HALTED;
      end
    endcase
    if (w_retire) begin
      w_next_state = (pc_next == HALT_ADDR) ? S_HALTED : S_FETCH;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_FETCH;
      r_illegal     <= 1'b0;
      r_cycle_count <= '0;
      r_instr_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_set_illegal) r_illegal <= 1'b1;
      if (r_state != S_HALTED) begin
        if (r_cycle_count != '1) r_cycle_count <= r_cycle_count + c_ONE;
        if (w_retire && (r_instr_count != '1)) r_instr_count <= r_instr_count + c_ONE;
      end
    end
  end

  assign state       = r_state;
  assign active      = (r_state != S_HALTED);
  assign illegal     = r_illegal;
  assign cycle_count = r_cycle_count;
  assign instr_count = r_instr_count;

endmodule

`default_nettype wire

// File: tb/tb_mips_state_sequencer.sv
// ============================================================================
// Module   : tb_mips_state_sequencer
// Brief    : Directed scoreboard bench for mips_state_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_state_sequencer;

  localparam logic [5:0] c_OP_R     = 6'b000000;
  localparam logic [5:0] c_FN_ADDU  = 6'b100001;
  localparam logic [5:0] c_FN_JR    = 6'b001000;
  localparam logic [5:0] c_OP_ADDIU = 6'b001001;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_J     = 6'b000010;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rst4 = 1'b1;
  logic [5:0]  opcode = 6'd0;
  logic [5:0]  func_code = 6'd0;
  logic        waitrequest = 1'b0;
  logic [31:0] pc_next = 32'hBFC0_0004;

  logic [2:0]  state;
  logic        active;
  logic        illegal;
  logic [31:0] cycle_count;
  logic [31:0] instr_count;

  logic [2:0]  state4;
  logic        active4;
  logic        illegal4;
  logic [3:0]  cycle_count4;
  logic [3:0]  instr_count4;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];

  always #5 clk = ~clk;

  mips_state_sequencer #(.CNT_W(32), .HALT_ADDR(32'h0000_0000)) u_dut (
    .clk(clk), .reset(reset), .opcode(opcode), .func_code(func_code),
    .waitrequest(waitrequest), .pc_next(pc_next), .state(state), .active(active),
    .illegal(illegal), .cycle_count(cycle_count), .instr_count(instr_count)
  );

  mips_state_sequencer #(.CNT_W(4), .HALT_ADDR(32'h0000_0000)) u_dut4 (
    .clk(clk), .reset(rst4), .opcode(opcode), .func_code(func_code),
    .waitrequest(waitrequest), .pc_next(pc_next), .state(state4), .active(active4),
    .illegal(illegal4), .cycle_count(cycle_count4), .instr_count(instr_count4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] s);
    exp_q.push_back(s);
  endtask

  // Pop the next expected state and compare against the DUT.
  task automatic sample(input string tag);
    logic [2:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_scoreboard_empty observed=0x%0h expected=none", tag, state);
    end else begin
      e = exp_q.pop_front();
      check(tag, {29'd0, state}, {29'd0, e});
    end
  endtask

  task automatic step(input string tag, input logic wr);
    waitrequest = wr;
    @(posedge clk);
    @(negedge clk);
    sample(tag);
  endtask

  // Reset pulse that falls entirely between two clock edges.
  task automatic pulse_reset(input string tag);
    reset = 1'b1;
    #1;
    check({tag, "_rst_state"},  {29'd0, state}, 32'd0);
    check({tag, "_rst_active"}, {31'd0, active}, 32'd1);
    check({tag, "_rst_illegal"}, {31'd0, illegal}, 32'd0);
    check({tag, "_rst_cycles"}, cycle_count, 32'd0);
    check({tag, "_rst_instrs"}, instr_count, 32'd0);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    // ADDU, no stalls
    opcode = c_OP_R; func_code = c_FN_ADDU; pc_next = 32'hBFC0_0004;
    pulse_reset("init");
    push(3'd0); push(3'd1); push(3'd2); push(3'd3); push(3'd0);
    sample("addu");
    for (int i = 0; i < 4; i++) step("addu", 1'b0);
    check("addu_instrs", instr_count, 32'd1);
    check("addu_cycles", cycle_count, 32'd4);

    // LW with 2 fetch stalls and 3 memory stalls
    opcode = c_OP_LW; func_code = 6'd0;
    push(3'd0); push(3'd0); push(3'd0); push(3'd1); push(3'd2);
    push(3'd3); push(3'd3); push(3'd3); push(3'd3); push(3'd4); push(3'd0);
    sample("lw");
    step("lw", 1'b1); step("lw", 1'b1); step("lw", 1'b0);
    step("lw", 1'b0); step("lw", 1'b0);
    step("lw", 1'b1); step("lw", 1'b1); step("lw", 1'b1); step("lw", 1'b0);
    step("lw", 1'b0);
    check("lw_instrs", instr_count, 32'd2);
    check("lw_cycles", cycle_count, 32'd14);

    // JR retiring to the halt address
    opcode = c_OP_R; func_code = c_FN_JR; pc_next = 32'h0000_0000;
    pulse_reset("jr");
    push(3'd0); push(3'd1); push(3'd2); push(3'd5);
    sample("jr");
    for (int i = 0; i < 3; i++) step("jr", 1'b0);
    check("jr_active", {31'd0, active}, 32'd0);
    check("jr_cycles", cycle_count, 32'd3);
    check("jr_instrs", instr_count, 32'd1);
    push(3'd5); push(3'd5); push(3'd5); push(3'd5);
    step("halted", 1'b1); step("halted", 1'b0); step("halted", 1'b1); step("halted", 1'b0);
    check("halted_cycles", cycle_count, 32'd3);
    check("halted_instrs", instr_count, 32'd1);
    check("halted_active", {31'd0, active}, 32'd0);

    // Unsupported J opcode
    opcode = c_OP_J; func_code = 6'd0; pc_next = 32'hBFC0_0004;
    pulse_reset("ill");
    push(3'd0); push(3'd1); push(3'd2); push(3'd5);
    sample("ill");
    for (int i = 0; i < 3; i++) step("ill", 1'b0);
    check("ill_flag", {31'd0, illegal}, 32'd1);
    check("ill_instrs", instr_count, 32'd0);
    check("ill_active", {31'd0, active}, 32'd0);
    pulse_reset("ill_clear");

    // SW stalled in memory, then reset mid-stall, then a clean SW
    opcode = c_OP_SW;
    push(3'd0); push(3'd1); push(3'd2); push(3'd3); push(3'd3); push(3'd3);
    sample("sw_stall");
    step("sw_stall", 1'b0); step("sw_stall", 1'b0); step("sw_stall", 1'b1);
    step("sw_stall", 1'b1); step("sw_stall", 1'b1);
    check("sw_stall_instrs", instr_count, 32'd0);
    pulse_reset("sw_mid");
    push(3'd0); push(3'd1); push(3'd2); push(3'd3); push(3'd0);
    sample("sw");
    for (int i = 0; i < 4; i++) step("sw", 1'b0);
    check("sw_instrs", instr_count, 32'd1);
    check("sw_cycles", cycle_count, 32'd4);
    check("queue_drained", exp_q.size(), 32'd0);

    // Counter saturation with a 4-bit instance running ADDIU
    opcode = c_OP_ADDIU; func_code = 6'd0; waitrequest = 1'b0;
    rst4 = 1'b0;
    check("sat_rst_state", {29'd0, state4}, 32'd0);
    check("sat_rst_cycles", {28'd0, cycle_count4}, 32'd0);
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 12) check("sat_cycles_12", {28'd0, cycle_count4}, 32'd12);
      if (i == 16) check("sat_cycles_16", {28'd0, cycle_count4}, 32'd15);
    end
    check("sat_cycles_final", {28'd0, cycle_count4}, 32'd15);
    check("sat_instrs_final", {28'd0, instr_count4}, 32'd5);
    check("sat_state_final", {29'd0, state4}, 32'd0);
    check("sat_active", {31'd0, active4}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
